// File: rtl/alt_vip_common_packet_encoder.sv
// Avalon-ST video packet encoder.
// Wraps an algorithm's pixel beats into video packets and emits control
// packets on request. A one-entry holding register decouples the algorithm
// from a registered output stage that only advances when the sink accepts.
module alt_vip_common_packet_encoder #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
  input  logic                                        write,
  input  logic                                        end_of_video_out,
  output logic                                        stall_out,
  input  logic [15:0]                                 width_out,
  input  logic [15:0]                                 height_out,
  input  logic [3:0]                                  interlaced_out,
  input  logic                                        vip_ctrl_send,
  output logic                                        vip_ctrl_busy,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        dout_startofpacket,
  output logic                                        dout_endofpacket
);

  localparam int DW          = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int NUM_NIBBLES = 9;
  localparam int BODY_BEATS  = (NUM_NIBBLES + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;
  localparam logic [3:0] LAST_BODY = 4'(BODY_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CTRL_BODY,
    VID_DATA
  } state_e;

  state_e          state_q, state_d;
  logic            dout_valid_q, dout_valid_d;
  logic [DW-1:0]   dout_data_q, dout_data_d;
  logic            dout_sop_q, dout_sop_d;
  logic            dout_eop_q, dout_eop_d;
  logic            hold_full_q, hold_full_d;
  logic            hold_eov_q, hold_eov_d;
  logic [DW-1:0]   hold_data_q, hold_data_d;
  logic            ctrl_pending_q, ctrl_pending_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic [15:0]     ctrl_width_q, ctrl_width_d;
  logic [15:0]     ctrl_height_q, ctrl_height_d;
  logic [3:0]      ctrl_interlaced_q, ctrl_interlaced_d;

  logic            advance;
  logic            accept;
  logic            ctrl_accept;
  logic [63:0]     nibble_vec;
  logic [DW-1:0]   body_beat;
  int              nib_idx;

  // Handshake terms: output advance, algorithm back-pressure, control busy.
  always_comb begin
    advance       = ~dout_valid_q | dout_ready;
    stall_out     = hold_full_q & ~((state_q == VID_DATA) & advance);
    vip_ctrl_busy = ctrl_pending_q | (state_q == CTRL_BODY);
    accept        = write & ~stall_out;
    ctrl_accept   = vip_ctrl_send & ~vip_ctrl_busy;
  end

  // Control body beat: nibble i of {width, height, interlaced} lands in the
  // low four bits of symbol (i mod SPB) of body beat (i div SPB).
  always_comb begin
    nibble_vec = {ctrl_width_q, ctrl_height_q, ctrl_interlaced_q, 28'd0};
    body_beat  = '0;
    nib_idx    = 0;
    for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
      nib_idx = int'(beat_cnt_q) * SYMBOLS_PER_BEAT + s;
      if (nib_idx < NUM_NIBBLES) begin
        body_beat[s*BITS_PER_SYMBOL +: 4] = nibble_vec[60 - 4*nib_idx +: 4];
      end
    end
  end

  // Next-state logic for the packet FSM, output stage, holding register and
  // control request latch.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d           = state_q;
    dout_valid_d      = dout_valid_q;
    dout_data_d       = dout_data_q;
    dout_sop_d        = dout_sop_q;
    dout_eop_d        = dout_eop_q;
    hold_full_d       = hold_full_q;
    hold_eov_d        = hold_eov_q;
    hold_data_d       = hold_data_q;
    ctrl_pending_d    = ctrl_pending_q;
    beat_cnt_d        = beat_cnt_q;
    ctrl_width_d      = ctrl_width_q;
    ctrl_height_d     = ctrl_height_q;
    ctrl_interlaced_d = ctrl_interlaced_q;

    if (advance) begin
      dout_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (ctrl_pending_q) begin
            dout_valid_d   = 1'b1;
            dout_data_d    = DW'(4'hF);
            dout_sop_d     = 1'b1;
            dout_eop_d     = 1'b0;
            ctrl_pending_d = 1'b0;
            beat_cnt_d     = 4'd0;
            state_d        = CTRL_BODY;
          end else if (hold_full_q) begin
            dout_valid_d = 1'b1;
            dout_data_d  = '0;
            dout_sop_d   = 1'b1;
            dout_eop_d   = 1'b0;
            state_d      = VID_DATA;
          end
        end
        CTRL_BODY: begin
          dout_valid_d = 1'b1;
          dout_data_d  = body_beat;
          dout_sop_d   = 1'b0;
          dout_eop_d   = (beat_cnt_q == LAST_BODY);
          beat_cnt_d   = beat_cnt_q + 4'd1;
          if (beat_cnt_q == LAST_BODY) state_d = IDLE;
        end
        VID_DATA: begin
          if (hold_full_q) begin
            dout_valid_d = 1'b1;
            dout_data_d  = hold_data_q;
            dout_sop_d   = 1'b0;
            dout_eop_d   = hold_eov_q;
            hold_full_d  = 1'b0;
            if (hold_eov_q) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A write may refill the holding register in the cycle it drains.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = data_out;
      hold_eov_d  = end_of_video_out;
    end

    if (ctrl_accept) begin
      ctrl_pending_d    = 1'b1;
      ctrl_width_d      = width_out;
      ctrl_height_d     = height_out;
      ctrl_interlaced_d = interlaced_out;
    end
  end

  // Control state and output stage; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      state_q        <= IDLE;
      dout_valid_q   <= 1'b0;
      dout_data_q    <= '0;
      dout_sop_q     <= 1'b0;
      dout_eop_q     <= 1'b0;
      hold_full_q    <= 1'b0;
      hold_eov_q     <= 1'b0;
      ctrl_pending_q <= 1'b0;
      beat_cnt_q     <= 4'd0;
    end else begin
      state_q        <= state_d;
      dout_valid_q   <= dout_valid_d;
      dout_data_q    <= dout_data_d;
      dout_sop_q     <= dout_sop_d;
      dout_eop_q     <= dout_eop_d;
      hold_full_q    <= hold_full_d;
      hold_eov_q     <= hold_eov_d;
      ctrl_pending_q <= ctrl_pending_d;
      beat_cnt_q     <= beat_cnt_d;
    end
  end

  // Payload registers, only ever read while their qualifying flag is set.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is left without reset; the full/pending flags
    // guard every read, so resetting it would only add fan-out.
    hold_data_q       <= hold_data_d;
    ctrl_width_q      <= ctrl_width_d;
    ctrl_height_q     <= ctrl_height_d;
    ctrl_interlaced_q <= ctrl_interlaced_d;
  end

  assign dout_valid         = dout_valid_q;
  assign dout_data          = dout_data_q;
  assign dout_startofpacket = dout_sop_q;
  assign dout_endofpacket   = dout_eop_q;

endmodule

// File: tb/tb_alt_vip_common_packet_encoder.sv
// Testbench for alt_vip_common_packet_encoder: directed scenarios plus a
// randomized run, with a packet-level reference model checking every beat.
module tb_alt_vip_common_packet_encoder;

  localparam int BPS = 8;
  localparam int SPB = 3;
  localparam int DW  = BPS * SPB;
  localparam int NB  = (9 + SPB - 1) / SPB;
  localparam logic [DW-1:0] CTRL_HDR = DW'(4'hF);

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] h;
    logic [3:0]  il;
  } ctrl_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eov;
  } vid_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_out;
  logic          write;
  logic          end_of_video_out;
  logic          stall_out;
  logic [15:0]   width_out;
  logic [15:0]   height_out;
  logic [3:0]    interlaced_out;
  logic          vip_ctrl_send;
  logic          vip_ctrl_busy;
  logic          dout_ready;
  logic          dout_valid;
  logic [DW-1:0] dout_data;
  logic          dout_startofpacket;
  logic          dout_endofpacket;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected packets in order of acceptance.
  ctrl_t exp_ctrl[$];
  vid_t  exp_video[$];
  bit    pkt_kinds[$];   // 1 = control packet, 0 = video packet
  int    ctrl_inflight = 0;
  bit    in_pkt = 0;
  bit    is_ctrl = 0;
  int    beat_idx = 0;
  ctrl_t cur_ctrl;

  bit            have_prev = 0;
  logic [DW-1:0] prev_data;
  logic          prev_sop;
  logic          prev_eop;

  alt_vip_common_packet_encoder #(
    .BITS_PER_SYMBOL (BPS),
    .SYMBOLS_PER_BEAT(SPB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .data_out          (data_out),
    .write             (write),
    .end_of_video_out  (end_of_video_out),
    .stall_out         (stall_out),
    .width_out         (width_out),
    .height_out        (height_out),
    .interlaced_out    (interlaced_out),
    .vip_ctrl_send     (vip_ctrl_send),
    .vip_ctrl_busy     (vip_ctrl_busy),
    .dout_ready        (dout_ready),
    .dout_valid        (dout_valid),
    .dout_data         (dout_data),
    .dout_startofpacket(dout_startofpacket),
    .dout_endofpacket  (dout_endofpacket)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected control body beat b: nibble list width (MS first), height
  // (MS first), interlaced; nibble n goes to symbol n%SPB of beat n/SPB.
  function automatic logic [DW-1:0] ctrl_beat(input ctrl_t c, input int b);
    int     nibs[9];
    longint acc;
    int     n;
    for (int k = 0; k < 4; k++) begin
      nibs[k]     = (int'(c.w) >> (12 - 4*k)) & 15;
      nibs[4 + k] = (int'(c.h) >> (12 - 4*k)) & 15;
    end
    nibs[8] = int'(c.il);
    acc = 0;
    for (int s = 0; s < SPB; s++) begin
      n = b * SPB + s;
      if (n < 9) acc = acc + (longint'(nibs[n]) << (s * BPS));
    end
    return acc[DW-1:0];
  endfunction

  task automatic take_beat();
    vid_t e;
    if (dout_startofpacket) begin
      check("sop_inside_packet", in_pkt, 0);
      check("header_eop", dout_endofpacket, 0);
      beat_idx = 0;
      in_pkt   = 1;
      if (dout_data == CTRL_HDR) begin
        is_ctrl = 1;
        pkt_kinds.push_back(1'b1);
        check("ctrl_packet_expected", exp_ctrl.size() != 0, 1);
        if (exp_ctrl.size() != 0) cur_ctrl = exp_ctrl.pop_front();
      end else begin
        is_ctrl = 0;
        pkt_kinds.push_back(1'b0);
        check("video_header", dout_data, '0);
      end
    end else if (!in_pkt) begin
      check("beat_outside_packet", 1, 0);
    end else if (is_ctrl) begin
      check("ctrl_body", dout_data, ctrl_beat(cur_ctrl, beat_idx));
      check("ctrl_body_eop", dout_endofpacket, beat_idx == NB - 1);
      beat_idx++;
      if (beat_idx == NB) begin
        in_pkt = 0;
        ctrl_inflight--;
      end
    end else begin
      check("video_beat_expected", exp_video.size() != 0, 1);
      if (exp_video.size() != 0) begin
        e = exp_video.pop_front();
        check("video_data", dout_data, e.data);
        check("video_eop", dout_endofpacket, e.eov);
        if (e.eov) in_pkt = 0;
      end
    end
  endtask

  // Monitor: inputs are stable from +1 after posedge, so the negedge sees
  // exactly what the next posedge will sample.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt    = 0;
      have_prev = 0;
    end else begin
      if (have_prev) begin
        check("stall_valid_held", dout_valid, 1);
        check("stall_data_held", dout_data, prev_data);
        check("stall_sop_held", dout_startofpacket, prev_sop);
        check("stall_eop_held", dout_endofpacket, prev_eop);
      end
      have_prev = dout_valid && !dout_ready;
      prev_data = dout_data;
      prev_sop  = dout_startofpacket;
      prev_eop  = dout_endofpacket;
      if (dout_valid && dout_ready) take_beat();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic eov);
    vid_t e;
    write            = 1'b1;
    data_out         = d;
    end_of_video_out = eov;
    e.data = d;
    e.eov  = eov;
    exp_video.push_back(e);
  endtask

  task automatic send(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                      input bit expect_accept);
    ctrl_t c;
    vip_ctrl_send  = 1'b1;
    width_out      = w;
    height_out     = h;
    interlaced_out = il;
    if (expect_accept) begin
      c.w  = w;
      c.h  = h;
      c.il = il;
      exp_ctrl.push_back(c);
      ctrl_inflight++;
    end
  endtask

  // Waits (bounded) for stall_out low, then writes one beat.
  task automatic do_write(input logic [DW-1:0] d, input logic eov);
    int waited = 0;
    #1;
    while (stall_out && waited < 50) begin
      step();
      #1;
      waited++;
    end
    check("write_wait_bound", waited < 50, 1);
    if (waited < 50) begin
      put(d, eov);
      step();
      write = 1'b0;
    end
  endtask

  task automatic drain();
    int waited = 0;
    write         = 1'b0;
    vip_ctrl_send = 1'b0;
    dout_ready    = 1'b1;
    while ((exp_video.size() != 0 || exp_ctrl.size() != 0 || in_pkt || ctrl_inflight != 0)
           && waited < 300) begin
      step();
      waited++;
    end
    check("drain_bound", waited < 300, 1);
    step();
    step();
    check("drain_idle_valid", dout_valid, 0);
  endtask

  initial begin
    logic [DW-1:0] e_data[7];
    logic          e_valid[7];
    logic          e_busy[7];
    logic          e_stall[7];
    int            busy_cnt;
    logic [DW-1:0] d0;
    bit            frame_open;
    bit            just_sent;

    rst = 1'b1;
    data_out = '0; write = 1'b0; end_of_video_out = 1'b0;
    width_out = '0; height_out = '0; interlaced_out = '0;
    vip_ctrl_send = 1'b0; dout_ready = 1'b1;

    // Reset wins over simultaneous write and control request.
    write = 1'b1; data_out = 24'hABCDEF; end_of_video_out = 1'b1;
    vip_ctrl_send = 1'b1; width_out = 16'd10; height_out = 16'd20;
    step();
    step();
    check("rst_valid", dout_valid, 0);
    check("rst_sop", dout_startofpacket, 0);
    check("rst_eop", dout_endofpacket, 0);
    check("rst_data", dout_data, '0);
    check("rst_busy", vip_ctrl_busy, 0);
    check("rst_stall", stall_out, 0);
    rst = 1'b0; write = 1'b0; vip_ctrl_send = 1'b0; end_of_video_out = 1'b0;
    step();
    step();
    check("post_rst_valid", dout_valid, 0);
    check("post_rst_busy", vip_ctrl_busy, 0);

    // Control packet 640x480 progressive.
    e_data[0] = '0;          e_data[1] = '0;          e_data[2] = 24'h00000F;
    e_data[3] = 24'h080200;  e_data[4] = 24'h010000;  e_data[5] = 24'h00000E;
    e_data[6] = '0;
    e_valid[0] = 0; e_valid[1] = 0; e_valid[2] = 1; e_valid[3] = 1;
    e_valid[4] = 1; e_valid[5] = 1; e_valid[6] = 0;
    e_busy[0] = 0; e_busy[1] = 1; e_busy[2] = 1; e_busy[3] = 1;
    e_busy[4] = 1; e_busy[5] = 0; e_busy[6] = 0;
    busy_cnt = 0;
    for (int t = 0; t < 7; t++) begin
      if (t == 0) send(16'd640, 16'd480, 4'd0, 1);
      else vip_ctrl_send = 1'b0;
      #1;
      check($sformatf("ctrl640_busy_t%0d", t), vip_ctrl_busy, e_busy[t]);
      check($sformatf("ctrl640_valid_t%0d", t), dout_valid, e_valid[t]);
      if (e_valid[t]) begin
        check($sformatf("ctrl640_data_t%0d", t), dout_data, e_data[t]);
        check($sformatf("ctrl640_sop_t%0d", t), dout_startofpacket, t == 2);
        check($sformatf("ctrl640_eop_t%0d", t), dout_endofpacket, t == 5);
      end
      if (vip_ctrl_busy) busy_cnt++;
      step();
    end
    check("ctrl640_busy_cycles", busy_cnt, 4);

    // Three back-to-back writes at full rate.
    e_data[2] = '0;         e_data[3] = 24'h111111;
    e_data[4] = 24'h222222; e_data[5] = 24'h333333;
    e_stall[0] = 0; e_stall[1] = 1; e_stall[2] = 0; e_stall[3] = 0;
    e_stall[4] = 0; e_stall[5] = 0; e_stall[6] = 0;
    for (int t = 0; t < 7; t++) begin
      write = 1'b0;
      if (t == 0) put(24'h111111, 1'b0);
      if (t == 2) put(24'h222222, 1'b0);
      if (t == 3) put(24'h333333, 1'b1);
      #1;
      check($sformatf("b2b_stall_t%0d", t), stall_out, e_stall[t]);
      check($sformatf("b2b_valid_t%0d", t), dout_valid, e_valid[t]);
      if (e_valid[t]) begin
        check($sformatf("b2b_data_t%0d", t), dout_data, e_data[t]);
        check($sformatf("b2b_sop_t%0d", t), dout_startofpacket, t == 2);
        check($sformatf("b2b_eop_t%0d", t), dout_endofpacket, t == 5);
      end
      step();
    end
    write = 1'b0;
    drain();

    // Back-pressure for five cycles mid-frame.
    do_write(24'hA0A0A1, 1'b0);
    do_write(24'hA0A0A2, 1'b0);
    d0 = dout_data;
    for (int t = 0; t < 5; t++) begin
      dout_ready = 1'b0;
      #1;
      check($sformatf("bp_stall_t%0d", t), stall_out, 1);
      check($sformatf("bp_data_t%0d", t), dout_data, d0);
      step();
    end
    dout_ready = 1'b1;
    do_write(24'hA0A0A3, 1'b1);
    drain();

    // Control request and first write in the same idle cycle.
    pkt_kinds.delete();
    #1;
    check("same_cycle_stall", stall_out, 0);
    send(16'h1234, 16'h5678, 4'h9, 1);
    put(24'hC0FFEE, 1'b0);
    step();
    vip_ctrl_send = 1'b0;
    write = 1'b0;
    do_write(24'hBEEF01, 1'b1);
    drain();
    check("same_cycle_pkt_count", pkt_kinds.size(), 2);
    if (pkt_kinds.size() == 2) begin
      check("same_cycle_first_ctrl", pkt_kinds[0], 1);
      check("same_cycle_then_video", pkt_kinds[1], 0);
    end

    // Control request during video, second request while busy is ignored.
    pkt_kinds.delete();
    do_write(24'h0D0D01, 1'b0);
    step();
    send(16'hFEDC, 16'h0BA9, 4'h3, 1);
    #1;
    check("mid_video_busy_before", vip_ctrl_busy, 0);
    step();
    send(16'h1111, 16'h2222, 4'h5, 0);
    #1;
    check("mid_video_busy_after", vip_ctrl_busy, 1);
    step();
    vip_ctrl_send = 1'b0;
    do_write(24'h0D0D02, 1'b1);
    drain();
    check("mid_video_pkt_count", pkt_kinds.size(), 2);
    if (pkt_kinds.size() == 2) begin
      check("mid_video_first_video", pkt_kinds[0], 0);
      check("mid_video_then_ctrl", pkt_kinds[1], 1);
    end

    // Randomized traffic with random back-pressure and control requests.
    frame_open = 0;
    just_sent  = 0;
    for (int c = 0; c < 3000; c++) begin
      write         = 1'b0;
      vip_ctrl_send = 1'b0;
      dout_ready    = ($urandom_range(0, 3) != 0);
      if (just_sent) begin
        just_sent = 0;
        if ($urandom_range(0, 1) == 1)
          send(16'($urandom), 16'($urandom), 4'($urandom), 0);
      end else if (ctrl_inflight == 0 && $urandom_range(0, 39) == 0) begin
        send(16'($urandom), 16'($urandom), 4'($urandom), 1);
        just_sent = 1;
      end
      #1;
      if (!stall_out && $urandom_range(0, 3) != 0) begin
        put(DW'($urandom), $urandom_range(0, 5) == 0);
        frame_open = !end_of_video_out;
      end
      step();
    end
    write = 1'b0;
    vip_ctrl_send = 1'b0;
    dout_ready = 1'b1;
    if (frame_open) do_write(DW'($urandom), 1'b1);
    drain();

    // Reset in the middle of a video packet.
    do_write(24'h515151, 1'b0);
    do_write(24'h525252, 1'b0);
    step();
    rst = 1'b1;
    step();
    check("midrst_valid", dout_valid, 0);
    check("midrst_sop", dout_startofpacket, 0);
    check("midrst_eop", dout_endofpacket, 0);
    check("midrst_data", dout_data, '0);
    check("midrst_busy", vip_ctrl_busy, 0);
    check("midrst_stall", stall_out, 0);
    rst = 1'b0;
    exp_video.delete();
    pkt_kinds.delete();
    step();
    do_write(24'h535353, 1'b1);
    drain();
    check("midrst_pkt_count", pkt_kinds.size(), 1);
    if (pkt_kinds.size() == 1) check("midrst_new_video", pkt_kinds[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_vip_common_packet_encoder.md
ALT_VIP_COMMON_PACKET_ENCODER -- requirements
Module: alt_vip_common_packet_encoder

Interface
REQ-001 SHALL have parameter BITS_PER_SYMBOL, default 8, bits per symbol (>=4).
REQ-002 SHALL have parameter SYMBOLS_PER_BEAT, default 3, symbols per beat (1..3); data width DW = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_out  in  DW  algorithm pixel beat.
REQ-006 SHALL have port write  in  1  data_out valid; honoured only when stall_out=0.
REQ-007 SHALL have port end_of_video_out  in  1  qualifies write: beat is last of frame.
REQ-008 SHALL have port stall_out  out  1  algorithm must not write.
REQ-009 SHALL have ports width_out/height_out  in  16 each, interlaced_out  in  4: control-packet fields.
REQ-010 SHALL have port vip_ctrl_send  in  1  single-cycle request to emit a control packet.
REQ-011 SHALL have port vip_ctrl_busy  out  1  control request pending or in transmission.
REQ-012 SHALL have ports dout_ready in 1, dout_valid out 1, dout_data out DW, dout_startofpacket out 1, dout_endofpacket out 1: Avalon-ST video source.

Function
REQ-013 Output stage SHALL be registered; "advance" = ~dout_valid | dout_ready; output registers load only on advance; dout_valid deasserts on advance when no beat is loaded.
REQ-014 SHALL contain a one-entry holding register (data, eov flag, full flag); write with stall_out=0 loads it.
REQ-015 stall_out SHALL equal hold_full & ~(state==VID_DATA & advance), giving one beat/cycle sustained in VID_DATA.
REQ-016 vip_ctrl_send with vip_ctrl_busy=0 SHALL latch width/height/interlaced and set ctrl_pending; vip_ctrl_send while busy SHALL be ignored.
REQ-017 vip_ctrl_busy SHALL equal ctrl_pending | (state==CTRL_BODY).
REQ-018 States SHALL be IDLE, CTRL_BODY, VID_DATA.
REQ-019 IDLE on advance: ctrl_pending -> emit header beat (symbol0[3:0]=4'hF, all other bits 0, sop=1, eop=0), clear ctrl_pending, beat counter=0, go CTRL_BODY; else hold_full -> emit header (all zero, sop=1), go VID_DATA; control has priority when both present.
REQ-020 Control body SHALL carry 9 nibbles in order width[15:12],[11:8],[7:4],[3:0], height[15:12]..[3:0], interlaced[3:0], one nibble per symbol in bits [3:0], symbol 0 first (symbol k occupies dout_data[k*BPS +: BPS]); upper symbol bits and unused trailing symbols SHALL be 0.
REQ-021 CTRL_BODY SHALL emit ceil(9/SYMBOLS_PER_BEAT) beats, one per advance; last beat eop=1, then IDLE.
REQ-022 VID_DATA on advance with hold_full: emit hold data (sop=0, eop=hold eov), empty hold unless refilled same cycle; eop beat returns to IDLE. No hold data on advance: dout_valid=0, remain.
REQ-023 ctrl_pending raised during VID_DATA SHALL wait until the video packet's eop beat has been loaded.
REQ-024 dout_data/sop/eop SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-025 A frame of exactly one beat (write with end_of_video_out) SHALL produce header then single eop data beat.

Reset
REQ-026 rst SHALL force state=IDLE, dout_valid=0, dout_startofpacket=0, dout_endofpacket=0, dout_data=0, hold_full=0, ctrl_pending=0, vip_ctrl_busy=0, stall_out=0; mid-packet reset aborts the packet with no eop.

Verification
REQ-027 SPB=3, dout_ready=1, vip_ctrl_send with width=640 height=480 interlaced=0 -> beats 24'h00000F(sop), 24'h080200, 24'h010000, 24'h00000E(eop); busy high 4 cycles.
REQ-028 Writes 0x111111,0x222222,0x333333(eov) back-to-back, ready=1 -> header 0x000000(sop) then 3 data beats, eop on 0x333333, stall_out high only the cycle after first write.
REQ-029 dout_ready held low 5 cycles mid-frame -> dout_data stable, stall_out=1, no write lost or duplicated.
REQ-030 vip_ctrl_send and first write in same IDLE cycle -> complete control packet precedes video header.
REQ-031 vip_ctrl_send during VID_DATA, then second send while busy -> one control packet only, emitted after video eop.
REQ-032 rst asserted mid-video-packet -> all outputs at reset values next cycle; next frame starts with sop header.
